// File: rtl/addnot_accum_if.sv
// Valid/ready bundle between the a + ~b adder, the frame accumulator and its consumer.
// The master drives samples and takes frame results; the slave is the accumulator.
interface addnot_accum_if #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
);
  localparam int LOG_C = $clog2(COUNT);
  localparam int ACC_W = WIDTH + 1 + LOG_C;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [LOG_C:0]   out_gt;
  logic [LOG_C:0]   out_len;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_gt, out_len
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_sum, out_gt, out_len
  );
endinterface

// File: rtl/addnot_accum.sv
// Sums COUNT (WIDTH+1)-bit a + ~b results per frame, counts carries (a > b),
// and presents the frame totals on a held valid/ready output.
module addnot_accum #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
) (
  input logic          clock,
  input logic          reset,
  addnot_accum_if.slave bus
);
  localparam int LOG_C = $clog2(COUNT);
  localparam int ACC_W = WIDTH + 1 + LOG_C;
  localparam int CNT_W = LOG_C + 1;
  localparam logic [CNT_W-1:0] LAST_LEN = CNT_W'(COUNT - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] gt_reg, gt_next;
  logic [CNT_W-1:0] len_reg, len_next;
  logic [ACC_W-1:0] out_sum_reg, out_sum_next;
  logic [CNT_W-1:0] out_gt_reg, out_gt_next;
  logic [CNT_W-1:0] out_len_reg, out_len_next;
  logic             out_valid_reg, out_valid_next;
  logic             in_ready_reg, in_ready_next;

  logic             accept;
  logic             transfer;
  logic             close_frame;
  logic [ACC_W-1:0] acc_add;
  logic [CNT_W-1:0] gt_add;
  logic [CNT_W-1:0] len_add;

  // in_ready_reg is only ever high in ACCUM, so accept needs no state qualifier.
  assign accept   = bus.in_valid & in_ready_reg;
  assign transfer = out_valid_reg & bus.out_ready;

  assign acc_add = acc_reg + (accept ? ACC_W'(bus.in_data) : '0);
  assign gt_add  = gt_reg + CNT_W'(accept & bus.in_data[WIDTH]);
  assign len_add = len_reg + CNT_W'(accept);

  // An empty frame is never closed: flush needs stored samples or one arriving now.
  assign close_frame = (state_reg == ACCUM) &&
                       ((accept && (len_reg == LAST_LEN)) ||
                        (bus.flush && ((len_reg != '0) || accept)));

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    gt_next        = gt_reg;
    len_next       = len_reg;
    out_sum_next   = out_sum_reg;
    out_gt_next    = out_gt_reg;
    out_len_next   = out_len_reg;
    out_valid_next = out_valid_reg;

    case (state_reg)
      ACCUM: begin
        acc_next = acc_add;
        gt_next  = gt_add;
        len_next = len_add;
        if (close_frame) begin
          state_next     = HOLD;
          out_sum_next   = acc_add;
          out_gt_next    = gt_add;
          out_len_next   = len_add;
          out_valid_next = 1'b1;
        end
      end
      HOLD: begin
        if (transfer) begin
          state_next     = ACCUM;
          acc_next       = '0;
          gt_next        = '0;
          len_next       = '0;
          out_valid_next = 1'b0;
        end
      end
      default: state_next = ACCUM;
    endcase

    in_ready_next = (state_next == ACCUM);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ACCUM;
      acc_reg       <= '0;
      gt_reg        <= '0;
      len_reg       <= '0;
      out_sum_reg   <= '0;
      out_gt_reg    <= '0;
      out_len_reg   <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      gt_reg        <= gt_next;
      len_reg       <= len_next;
      out_sum_reg   <= out_sum_next;
      out_gt_reg    <= out_gt_next;
      out_len_reg   <= out_len_next;
      out_valid_reg <= out_valid_next;
      in_ready_reg  <= in_ready_next;
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sum   = out_sum_reg;
  assign bus.out_gt    = out_gt_reg;
  assign bus.out_len   = out_len_reg;

endmodule

// File: tb/tb_addnot_accum.sv
// Directed, table-driven bench for addnot_accum (WIDTH=8, COUNT=4).
module tb_addnot_accum;
  localparam int WIDTH = 8;
  localparam int COUNT = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  addnot_accum_if #(.WIDTH(WIDTH), .COUNT(COUNT)) bus ();

  addnot_accum #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // fmode: 0 = no flush, 1 = flush with last sample, 2 = flush one cycle after
  typedef struct {
    int             n;
    logic [3:0][8:0] s;
    int             fmode;
    int             sum;
    int             gt;
    int             len;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Present one sample from a negedge; returns at the negedge after it is accepted.
  task automatic send(input logic [8:0] d, input logic fl);
    int waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_timeout: in_ready got %b expected 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.flush    = fl;
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int sum, input int gt, input int len);
    chk({tag, "_valid"}, int'(bus.out_valid), 1);
    chk({tag, "_sum"}, int'(bus.out_sum), sum);
    chk({tag, "_gt"}, int'(bus.out_gt), gt);
    chk({tag, "_len"}, int'(bus.out_len), len);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
  endtask

  task automatic release_frame(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    chk({tag, "_drop_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_ready_back"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    vecs[0] = '{n: 4, s: {9'd248, 9'd262, 9'd248, 9'd262}, fmode: 0, sum: 1020, gt: 2, len: 4};
    vecs[1] = '{n: 4, s: {9'd511, 9'd511, 9'd511, 9'd511}, fmode: 0, sum: 2044, gt: 4, len: 4};
    vecs[2] = '{n: 4, s: {9'd100, 9'd100, 9'd100, 9'd100}, fmode: 1, sum: 400,  gt: 0, len: 4};
    vecs[3] = '{n: 2, s: {9'd0,   9'd0,   9'd262, 9'd262}, fmode: 2, sum: 524,  gt: 2, len: 2};
    vecs[4] = '{n: 1, s: {9'd0,   9'd0,   9'd0,   9'd5},   fmode: 1, sum: 5,    gt: 0, len: 1};
    vecs[5] = '{n: 4, s: {9'd1,   9'd256, 9'd0,   9'd300}, fmode: 0, sum: 557,  gt: 2, len: 4};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge clock);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_sum", int'(bus.out_sum), 0);
    chk("rst_out_gt", int'(bus.out_gt), 0);
    chk("rst_out_len", int'(bus.out_len), 0);
    reset = 1'b1;
    #1 chk("rel_in_ready_before_edge", int'(bus.in_ready), 0);
    @(negedge clock);
    chk("rel_in_ready_after_edge", int'(bus.in_ready), 1);

    // Flush on an empty frame must not emit anything
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    chk("empty_flush_valid", int'(bus.out_valid), 0);
    repeat (2) @(negedge clock);
    chk("empty_flush_valid_later", int'(bus.out_valid), 0);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      for (int k = 0; k < vecs[v].n; k++)
        send(vecs[v].s[k], (vecs[v].fmode == 1) && (k == vecs[v].n - 1));
      if (vecs[v].fmode == 2) begin
        chk({tag, "_no_valid_before_flush"}, int'(bus.out_valid), 0);
        bus.flush = 1'b1;
        @(negedge clock);
        bus.flush = 1'b0;
      end
      check_frame(tag, vecs[v].sum, vecs[v].gt, vecs[v].len);
      release_frame(tag);
      repeat (2) @(negedge clock);
      chk({tag, "_no_extra_frame"}, int'(bus.out_valid), 0);
    end

    // Backpressure: held outputs, flush ignored in HOLD, pending sample kept
    send(9'd10, 1'b0);
    send(9'd20, 1'b0);
    send(9'd30, 1'b0);
    send(9'd40, 1'b0);
    check_frame("bp", 100, 0, 4);
    bus.in_valid = 1'b1;
    bus.in_data  = 9'd511;
    bus.flush    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check_frame($sformatf("bp_hold%0d", c), 100, 0, 4);
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    chk("bp_drop_valid", int'(bus.out_valid), 0);
    chk("bp_ready_back", int'(bus.in_ready), 1);
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check_frame("bp_pending", 511, 1, 1);
    release_frame("bp_pending");

    // Asynchronous reset mid-frame discards the partial frame
    send(9'd7, 1'b0);
    send(9'd9, 1'b0);
    #2 reset = 1'b0;
    #1 chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1 chk("mid_rel_in_ready_before_edge", int'(bus.in_ready), 0);
    @(negedge clock);
    chk("mid_rel_in_ready", int'(bus.in_ready), 1);
    chk("mid_rel_out_valid", int'(bus.out_valid), 0);
    for (int k = 0; k < 4; k++) send(9'd1, 1'b0);
    check_frame("post_rst", 4, 0, 4);
    release_frame("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time got %0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
